// File: rtl/mono_sample_to_packet_converter.sv
// AXI4-Stream master that expands each mono sample into a two-beat stereo packet.
// A small FIFO buffers samples while the sink back-pressures, since the sample input has no ready.
module mono_sample_to_packet_converter #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESET,
  input  logic                              mono_sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]           mono_sample,
  output logic                              M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]             M_AXIS_TDATA,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_L = 2'd1,
    SEND_R = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic                    handshake;
  logic [DATA_WIDTH-1:0]   head_word;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign handshake  = tvalid_q && M_AXIS_TREADY;

  // Left-justify the sample so its sign bit lands on the TDATA MSB.
  always_comb begin
    head_word = '0;
    head_word[DATA_WIDTH-1 -: SAMPLE_WIDTH] = mem_q[rd_ptr_q];
  end

  // Packet FSM: pops the FIFO head whenever a new packet starts.
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          tdata_d  = head_word;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = SEND_L;
        end
      end
      SEND_L: begin
        if (handshake) begin
          tlast_d = 1'b1;
          state_d = SEND_R;
        end
      end
      SEND_R: begin
        if (handshake) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            tdata_d  = head_word;
            tvalid_d = 1'b1;
            tlast_d  = 1'b0;
            state_d  = SEND_L;
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  always_comb begin
    push       = mono_sample_valid && (!fifo_full || pop);
    overflow_d = overflow_q || (mono_sample_valid && !push);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      state_q    <= IDLE;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= mono_sample;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_mono_sample_to_packet_converter.sv
// Scoreboard bench for mono_sample_to_packet_converter: expected beats are queued when
// samples are strobed and compared as the DUT hands them off.
module tb_mono_sample_to_packet_converter;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   logic        clock;
   logic        reset;
   logic        sampleValid;
   logic [23:0] sample;
   logic        tValid;
   logic [31:0] tData;
   logic        tLast;
   logic        tReady;
   logic [2:0]  fifoLevel;
   logic        overflow;

   beat_t       expQ[$];
   int          assertCount;
   int          failCount;
   int          handshakeCount;
   logic        prevStall;
   logic [31:0] prevData;
   logic        prevLast;

   mono_sample_to_packet_converter #(
      .DATA_WIDTH  (32),
      .SAMPLE_WIDTH(24),
      .FIFO_DEPTH  (4)
   ) dut (
      .M_AXIS_ACLK      (clock),
      .M_AXIS_ARESET    (reset),
      .mono_sample_valid(sampleValid),
      .mono_sample      (sample),
      .M_AXIS_TVALID    (tValid),
      .M_AXIS_TDATA     (tData),
      .M_AXIS_TLAST     (tLast),
      .M_AXIS_TREADY    (tReady),
      .fifo_level       (fifoLevel),
      .overflow         (overflow)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point; every check in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [31:0] mkWord(input logic [23:0] s);
      return {s, 8'h00};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Strobe one sample for one edge; queue its two beats if it should be accepted.
   task automatic applyStimulus(input logic [23:0] s, input bit expectAccept);
      sampleValid = 1'b1;
      sample      = s;
      if (expectAccept) begin
         expQ.push_back('{data: mkWord(s), last: 1'b0});
         expQ.push_back('{data: mkWord(s), last: 1'b1});
      end
      tick();
      sampleValid = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      bit drained;
      drained = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (expQ.size() == 0 && !tValid) begin
            drained = 1'b1;
            break;
         end
         tick();
      end
      checkOutput("drainDone", {63'd0, drained}, 64'd1);
   endtask

   task automatic resetDut();
      reset = 1'b1;
      #1;
      checkOutput("rstTvalid", {63'd0, tValid}, 64'd0);
      checkOutput("rstTlast", {63'd0, tLast}, 64'd0);
      checkOutput("rstTdata", {32'd0, tData}, 64'd0);
      checkOutput("rstLevel", {61'd0, fifoLevel}, 64'd0);
      checkOutput("rstOverflow", {63'd0, overflow}, 64'd0);
      expQ.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Beat monitor: compares handshakes against the scoreboard and checks stall stability.
   always @(negedge clock) begin
      if (reset) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("stallValid", {63'd0, tValid}, 64'd1);
            checkOutput("stallData", {32'd0, tData}, {32'd0, prevData});
            checkOutput("stallLast", {63'd0, tLast}, {63'd0, prevLast});
         end
         if (tValid && tReady) begin
            handshakeCount++;
            if (expQ.size() == 0) begin
               checkOutput("unexpectedBeat", {32'd0, tData}, 64'd0);
            end else begin
               beat_t exp;
               exp = expQ.pop_front();
               checkOutput("beatData", {32'd0, tData}, {32'd0, exp.data});
               checkOutput("beatLast", {63'd0, tLast}, {63'd0, exp.last});
            end
         end
         prevStall = tValid && !tReady;
         prevData  = tData;
         prevLast  = tLast;
      end
   end

   initial begin
      assertCount    = 0;
      failCount      = 0;
      handshakeCount = 0;
      prevStall      = 1'b0;
      prevData       = '0;
      prevLast       = 1'b0;
      reset          = 1'b0;
      sampleValid    = 1'b0;
      sample         = '0;
      tReady         = 1'b1;
      #2;
      resetDut();

      // Single positive sample: one-cycle latency from FIFO to output register.
      applyStimulus(24'h123456, 1'b1);
      checkOutput("levelAfterPush", {61'd0, fifoLevel}, 64'd1);
      checkOutput("validBeforePop", {63'd0, tValid}, 64'd0);
      tick();
      checkOutput("latencyValid", {63'd0, tValid}, 64'd1);
      checkOutput("latencyData", {32'd0, tData}, {32'd0, mkWord(24'h123456)});
      checkOutput("latencyLast", {63'd0, tLast}, 64'd0);
      checkOutput("levelAfterPop", {61'd0, fifoLevel}, 64'd0);
      waitDrain(50);
      checkOutput("idleLevel", {61'd0, fifoLevel}, 64'd0);

      // Negative sample keeps its sign bit at the MSB.
      applyStimulus(24'h800001, 1'b1);
      tick();
      checkOutput("negMsb", {63'd0, tData[31]}, 64'd1);
      waitDrain(50);
      checkOutput("negOverflow", {63'd0, overflow}, 64'd0);

      // Ready toggling inside one packet: exactly two handshakes.
      tReady = 1'b0;
      applyStimulus(24'h0abcde, 1'b1);
      tick();
      begin
         int hsBefore;
         hsBefore = handshakeCount;
         tReady = 1'b1; tick();
         tReady = 1'b0; tick();
         checkOutput("toggleHeldLast", {63'd0, tLast}, 64'd1);
         tReady = 1'b1; tick();
         tReady = 1'b0; tick();
         checkOutput("toggleHandshakes", 64'(handshakeCount - hsBefore), 64'd2);
         checkOutput("toggleIdle", {63'd0, tValid}, 64'd0);
      end
      tReady = 1'b1;
      waitDrain(50);

      // Back-pressure fill, overflow on the sixth sample, then a bubble-free drain.
      tReady = 1'b0;
      for (int i = 1; i <= 5; i++) applyStimulus(24'(i), 1'b1);
      checkOutput("fullLevel", {61'd0, fifoLevel}, 64'd4);
      checkOutput("fullNoOverflow", {63'd0, overflow}, 64'd0);
      checkOutput("fullHeadData", {32'd0, tData}, {32'd0, mkWord(24'd1)});
      applyStimulus(24'd6, 1'b0);
      checkOutput("dropOverflow", {63'd0, overflow}, 64'd1);
      checkOutput("dropLevel", {61'd0, fifoLevel}, 64'd4);
      tReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         checkOutput("noBubble", {63'd0, tValid}, 64'd1);
      end
      @(negedge clock);
      checkOutput("drainedIdle", {63'd0, tValid}, 64'd0);
      checkOutput("drainedQueue", 64'(expQ.size()), 64'd0);
      tick();
      checkOutput("overflowSticky", {63'd0, overflow}, 64'd1);

      resetDut();

      // Push on the same edge as a SEND_R pop with the FIFO full.
      tReady = 1'b0;
      for (int i = 1; i <= 5; i++) applyStimulus(24'(16 + i), 1'b1);
      checkOutput("simulFullLevel", {61'd0, fifoLevel}, 64'd4);
      tReady = 1'b1;
      tick();
      applyStimulus(24'h00abba, 1'b1);
      checkOutput("simulLevel", {61'd0, fifoLevel}, 64'd4);
      checkOutput("simulOverflow", {63'd0, overflow}, 64'd0);
      waitDrain(100);

      // Asynchronous reset between the left and right beats.
      tReady = 1'b0;
      applyStimulus(24'h654321, 1'b1);
      tick();
      tReady = 1'b1;
      tick();
      tReady = 1'b0;
      checkOutput("preRstLast", {63'd0, tLast}, 64'd1);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("asyncValid", {63'd0, tValid}, 64'd0);
      checkOutput("asyncLast", {63'd0, tLast}, 64'd0);
      checkOutput("asyncData", {32'd0, tData}, 64'd0);
      expQ.delete();
      tick();
      reset  = 1'b0;
      tReady = 1'b1;
      tick();
      tick();
      checkOutput("noRightBeat", {63'd0, tValid}, 64'd0);
      applyStimulus(24'h7fffff, 1'b1);
      tick();
      checkOutput("freshValid", {63'd0, tValid}, 64'd1);
      checkOutput("freshLast", {63'd0, tLast}, 64'd0);
      checkOutput("freshData", {32'd0, tData}, {32'd0, mkWord(24'h7fffff)});
      waitDrain(50);

      checkOutput("finalQueue", 64'(expQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
